// File: rtl/spi_sensor_regbank.sv
// rtl/spi_sensor_regbank.sv - SPI slave register bank with sensor snapshot load and burst access
module spi_sensor_regbank #(
    parameter int DATA_W   = 11,
    parameter int ADDR_W   = 4,
    parameter int BURST_EN = 1
) (
    input  logic                              spi_clk,
    input  logic                              rst,
    input  logic                              csb,
    input  logic                              mosi,
    output logic                              miso,
    input  logic                              ldb,
    input  logic [(2**ADDR_W)*DATA_W-1:0]     sensor_data,
    output logic                              frame_done,
    output logic                              wr_collision
);
    localparam int NUM_CH  = 2**ADDR_W;
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CONT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {HDR, DATA, CONT} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   hdr_addr, next_addr;
    logic [DATA_W-2:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   wdata;
    logic                miso_q, miso_d;
    logic                done_q, done_d;
    logic                coll_q, coll_d;
    logic                ldb_q;
    logic                load, wr_en, word_end;
    logic [DATA_W-1:0]   regs_q [NUM_CH];
    logic [DATA_W-1:0]   regs_d [NUM_CH];

    assign hdr_addr  = {addr_q[ADDR_W-2:0], mosi};
    assign next_addr = addr_q + ADDR_W'(1);
    assign wdata     = {shift_q, mosi};
    assign load      = ldb_q & ~ldb;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        shift_d  = shift_q;
        rdata_d  = rdata_q;
        miso_d   = miso_q;
        done_d   = 1'b0;
        coll_d   = coll_q;
        wr_en    = 1'b0;
        word_end = 1'b0;
        regs_d   = regs_q;

        if (csb) begin
            cnt_d   = '0;
            state_d = HDR;
            miso_d  = 1'b0;
            rdata_d = '0;
        end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            miso_d  = rdata_q[DATA_W-1];
            rdata_d = {rdata_q[DATA_W-2:0], 1'b0};
            unique case (state_q)
                HDR: begin
                    if (cnt_q == '0) rw_d = mosi;
                    else             addr_d = hdr_addr;
                    if (cnt_q == HDR_LAST) begin
                        state_d = DATA;
                        if (rw_q) begin
                            miso_d  = regs_q[hdr_addr][DATA_W-1];
                            rdata_d = {regs_q[hdr_addr][DATA_W-2:0], 1'b0};
                        end
                    end
                end
                DATA, CONT: begin
                    shift_d  = {shift_q[DATA_W-3:0], mosi};
                    word_end = (state_q == DATA) ? (cnt_q == DATA_LAST) : (cnt_q == CONT_LAST);
                    if (word_end) begin
                        done_d = 1'b1;
                        cnt_d  = '0;
                        wr_en  = ~rw_q;
                        // Burst: the next word is fetched on the same edge so its MSB is ready for bit 0
                        if (BURST_EN != 0) begin
                            state_d = CONT;
                            addr_d  = next_addr;
                            if (rw_q) begin
                                miso_d  = regs_q[next_addr][DATA_W-1];
                                rdata_d = {regs_q[next_addr][DATA_W-2:0], 1'b0};
                            end
                        end else begin
                            state_d = HDR;
                        end
                    end
                end
                default: state_d = HDR;
            endcase
        end

        if (load) begin
            for (int k = 0; k < NUM_CH; k++) regs_d[k] = sensor_data[k*DATA_W +: DATA_W];
            if (wr_en) coll_d = 1'b1;
        end else if (wr_en) begin
            regs_d[addr_q] = wdata;
        end
    end

    always_ff @(posedge spi_clk) begin
        if (rst) begin
            state_q <= HDR;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            shift_q <= '0;
            rdata_q <= '0;
            miso_q  <= 1'b0;
            done_q  <= 1'b0;
            coll_q  <= 1'b0;
            ldb_q   <= 1'b1;
            for (int k = 0; k < NUM_CH; k++) regs_q[k] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            rdata_q <= rdata_d;
            miso_q  <= miso_d;
            done_q  <= done_d;
            coll_q  <= coll_d;
            ldb_q   <= ldb;
            regs_q  <= regs_d;
        end
    end

    assign miso         = miso_q;
    assign frame_done   = done_q;
    assign wr_collision = coll_q;
endmodule
